// File: rtl/top_axi_slave.sv
// rtl/top_axi_slave.sv - AXI4-Lite write-only slave with an internal register file
// AW and W are captured independently; the write commits when the second one lands.
module top_axi_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;
  localparam int NUM_REGS  = 2 ** IDX_WIDTH;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                state, state_next;
  logic                  aw_captured, aw_captured_next;
  logic                  w_captured, w_captured_next;
  logic [IDX_WIDTH-1:0]  idx_q, idx_next;
  logic [DATA_WIDTH-1:0] data_q, data_next;
  logic                  awready_next, wready_next, bvalid_next;
  logic                  aw_hs, w_hs, commit;
  logic [IDX_WIDTH-1:0]  commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic                  unused_low_bits;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Byte-lane bits never select anything: unaligned writes hit the containing word.
  assign unused_low_bits = ^s_axi_awaddr[1:0];

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign commit_idx  = aw_hs ? s_axi_awaddr[ADDR_WIDTH-1:2] : idx_q;
  assign commit_data = w_hs ? s_axi_wdata : data_q;
  assign s_axi_bresp = RESP_OKAY;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      aw_captured   <= 1'b0;
      w_captured    <= 1'b0;
      idx_q         <= '0;
      data_q        <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      state         <= state_next;
      aw_captured   <= aw_captured_next;
      w_captured    <= w_captured_next;
      idx_q         <= idx_next;
      data_q        <= data_next;
      s_axi_awready <= awready_next;
      s_axi_wready  <= wready_next;
      s_axi_bvalid  <= bvalid_next;
    end
  end

  always_comb begin
    state_next       = state;
    aw_captured_next = aw_captured;
    w_captured_next  = w_captured;
    idx_next         = idx_q;
    data_next        = data_q;
    awready_next     = s_axi_awready;
    wready_next      = s_axi_wready;
    bvalid_next      = s_axi_bvalid;
    commit           = 1'b0;
    case (state)
      IDLE: begin
        if (aw_hs) begin
          aw_captured_next = 1'b1;
          idx_next         = s_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_captured_next = 1'b1;
          data_next       = s_axi_wdata;
        end
        // Readies track the captured flags, which also raises them on the first edge out of reset.
        awready_next = !aw_captured_next;
        wready_next  = !w_captured_next;
        if ((aw_captured || aw_hs) && (w_captured || w_hs)) begin
          commit       = 1'b1;
          bvalid_next  = 1'b1;
          awready_next = 1'b0;
          wready_next  = 1'b0;
          state_next   = RESP;
        end
      end
      RESP: begin
        if (s_axi_bready) begin
          bvalid_next      = 1'b0;
          aw_captured_next = 1'b0;
          w_captured_next  = 1'b0;
          awready_next     = 1'b1;
          wready_next      = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[commit_idx] <= commit_data;
    end
  end

endmodule

// File: tb/tb_top_axi_slave.sv
// tb/tb_top_axi_slave.sv - scoreboard bench for top_axi_slave
// Stimulus pushes expected writes; a monitor pops one per B response and checks the register file.
module tb_top_axi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_regs [4];
  int          checks   = 0;
  int          failures = 0;

  top_axi_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every rising bvalid is one response; retire the oldest expected write.
  initial begin : monitor
    logic prev_bvalid;
    exp_t e;
    prev_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (bvalid === 1'b1 && !prev_bvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_bresponse", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          model_regs[e.idx] = e.data;
          chk("bresp", {30'd0, bresp}, 32'd0);
          for (int i = 0; i < 4; i++)
            chk($sformatf("regs[%0d]", i), dut.regs[i], model_regs[i]);
        end
      end
      prev_bvalid = (bvalid === 1'b1);
    end
  end

  // Inputs change at negedge; a ready seen high at a negedge means the next posedge handshakes.
  task automatic drive(input bit en_aw, input logic [3:0] addr, input bit en_w, input logic [31:0] data);
    bit a_pend, w_pend, a_go, w_go;
    int n;
    a_pend = en_aw;
    w_pend = en_w;
    n = 0;
    if (en_aw) begin awaddr = addr; awvalid = 1'b1; end
    if (en_w)  begin wdata  = data; wvalid  = 1'b1; end
    while ((a_pend || w_pend) && n < 40) begin
      a_go = a_pend && (awready === 1'b1);
      w_go = w_pend && (wready === 1'b1);
      @(negedge clk);
      n++;
      if (a_go) begin awvalid = 1'b0; a_pend = 1'b0; end
      if (w_go) begin wvalid  = 1'b0; w_pend = 1'b0; end
    end
    if (a_pend || w_pend) begin
      chk("handshake_timeout", 32'd1, 32'd0);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
  endtask

  task automatic write_both(input logic [3:0] addr, input logic [31:0] data);
    sb.push_back('{idx: addr[3:2], data: data});
    drive(1'b1, addr, 1'b1, data);
  endtask

  initial begin : stimulus
    rst_n   = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_regs[%0d]", i), dut.regs[i], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_awready", {31'd0, awready}, 32'd1);
    chk("rel_wready",  {31'd0, wready},  32'd1);

    // Simultaneous write with single-cycle B latency
    bready = 1'b1;
    write_both(4'h0, 32'hDEADBEEF);
    chk("sim_bvalid_after_n", {31'd0, bvalid}, 32'd1);
    chk("sim_awready_after_n", {31'd0, awready}, 32'd0);
    @(negedge clk);
    chk("sim_bvalid_after_n1", {31'd0, bvalid}, 32'd0);
    chk("sim_awready_after_n1", {31'd0, awready}, 32'd1);
    chk("sim_wready_after_n1", {31'd0, wready}, 32'd1);

    // Second write
    write_both(4'h4, 32'h12345678);
    @(negedge clk);

    // Split channels: AW first, W three cycles later
    sb.push_back('{idx: 2'd3, data: 32'hA5A5A5A5});
    drive(1'b1, 4'hC, 1'b0, 32'd0);
    chk("split_awready", {31'd0, awready}, 32'd0);
    chk("split_wready",  {31'd0, wready},  32'd1);
    chk("split_bvalid",  {31'd0, bvalid},  32'd0);
    repeat (2) @(negedge clk);
    chk("split_bvalid_wait", {31'd0, bvalid}, 32'd0);
    chk("split_regs3_wait", dut.regs[3], 32'd0);
    drive(1'b0, 4'h0, 1'b1, 32'hA5A5A5A5);
    chk("split_bvalid_commit", {31'd0, bvalid}, 32'd1);
    @(negedge clk);

    // Back-pressure, with an unaligned write waiting behind it
    bready = 1'b0;
    write_both(4'h8, 32'h0BADF00D);
    sb.push_back('{idx: 2'd0, data: 32'h11223344});
    awaddr = 4'h1; awvalid = 1'b1; wdata = 32'h11223344; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_bvalid_%0d", i),  {31'd0, bvalid},  32'd1);
      chk($sformatf("bp_awready_%0d", i), {31'd0, awready}, 32'd0);
      chk($sformatf("bp_wready_%0d", i),  {31'd0, wready},  32'd0);
      @(negedge clk);
    end
    chk("bp_regs0_held", dut.regs[0], 32'hDEADBEEF);
    bready = 1'b1;
    drive(1'b1, 4'h1, 1'b1, 32'h11223344);
    chk("bp_pending_bvalid", {31'd0, bvalid}, 32'd1);
    @(negedge clk);

    // Reset mid-transaction after AW only
    drive(1'b1, 4'h8, 1'b0, 32'd0);
    chk("mid_awready", {31'd0, awready}, 32'd0);
    rst_n = 1'b0;
    wdata = 32'hFFFFFFFF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("mid_rst_awready", {31'd0, awready}, 32'd0);
    chk("mid_rst_wready",  {31'd0, wready},  32'd0);
    chk("mid_rst_bvalid",  {31'd0, bvalid},  32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_rst_regs[%0d]", i), dut.regs[i], 32'd0);
      model_regs[i] = '0;
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery write after the aborted transaction
    write_both(4'hB, 32'h5555AAAA);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
